// File: rtl/mc_core_gen2_if.sv
// rtl/mc_core_gen2_if.sv - unified instruction/data memory port with req/ack handshake
interface mc_core_gen2_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mc_core_gen2.sv
// rtl/mc_core_gen2.sv - multicycle CPU core with integrated control FSM
// Single shared memory port; register file r0 reads zero; HALT is terminal until reset.
module mc_core_gen2 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  mc_core_gen2_if.master     mem,
  output logic               halted,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h05;
  localparam logic [5:0] OP_ORI  = 6'h06;
  localparam logic [5:0] OP_LW   = 6'h07;
  localparam logic [5:0] OP_SW   = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_J    = 6'h0A;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0] rf [32];

  logic [5:0]        op;
  logic [4:0]        r1, r2, r3;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [DATA_W-1:0] imm_se, imm_ze, alu_res;
  logic [ADDR_W-1:0] br_off, j_target;
  logic              known_op;

  assign op       = ir[31:26];
  assign r1       = ir[25:21];
  assign r2       = ir[20:16];
  assign r3       = ir[15:11];
  assign imm16    = ir[15:0];
  assign imm26    = ir[25:0];
  assign imm_se   = DATA_W'($signed(imm16));
  assign imm_ze   = DATA_W'(imm16);
  assign br_off   = ADDR_W'($signed(imm16));
  assign j_target = ADDR_W'(imm26);

  always_comb begin
    known_op = 1'b0;
    case (op)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ORI,
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: known_op = 1'b1;
      default:                             known_op = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:                alu_res = a_q + b_q;
      OP_SUB:                alu_res = a_q - b_q;
      OP_AND:                alu_res = a_q & b_q;
      OP_OR:                 alu_res = a_q | b_q;
      OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_se;
      OP_ORI:                alu_res = a_q | imm_ze;
      default:               alu_res = '0;
    endcase
  end

  // Reset gates mem_req directly so an in-flight request is dropped in the same cycle.
  assign mem.mem_req   = !reset && (state == S_FETCH || state == S_MEM);
  assign mem.mem_we    = (state == S_MEM) && (op == OP_SW);
  assign mem.mem_addr  = (state == S_MEM) ? ADDR_W'(alu_q) : pc;
  assign mem.mem_wdata = b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      retired    <= '0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        S_FETCH: begin
          if (mem.mem_ack) begin
            ir    <= 32'(mem.mem_rdata);
            pc    <= pc + ADDR_W'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rf[r2];
          b_q <= (op == OP_SW || op == OP_BEQ) ? rf[r1] : rf[r3];
          case (op)
            OP_HALT: begin
              halted  <= 1'b1;
              retired <= retired + CNT_W'(1);
              state   <= S_HALTED;
            end
            OP_J: begin
              pc      <= j_target;
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end
            OP_NOP: begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end
            default: begin
              if (known_op) begin
                state <= S_EXEC;
              end else begin
                illegal_op <= 1'b1;
                retired    <= retired + CNT_W'(1);
                state      <= S_FETCH;
              end
            end
          endcase
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (op == OP_BEQ) begin
            // pc already holds the fetched address + 1
            if (a_q == b_q) pc <= pc + br_off;
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end else if (op == OP_LW || op == OP_SW) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem.mem_ack) begin
            if (op == OP_SW) begin
              retired <= retired + CNT_W'(1);
              state   <= S_FETCH;
            end else begin
              mdr_q <= mem.mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (r1 != 5'd0) rf[r1] <= (op == OP_LW) ? mdr_q : alu_q;
          retired <= retired + CNT_W'(1);
          state   <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_gen2.sv
// tb/tb_mc_core_gen2.sv - self-checking bench for mc_core_gen2
module tb_mc_core_gen2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 32;

  localparam logic [5:0] OP_NOP  = 6'h00, OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04, OP_ADDI = 6'h05, OP_ORI = 6'h06, OP_LW = 6'h07;
  localparam logic [5:0] OP_SW   = 6'h08, OP_BEQ = 6'h09, OP_J = 6'h0A, OP_HALT = 6'h3F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_core_gen2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();
  logic              halted, illegal_op;
  logic [CNT_W-1:0]  retired;
  logic [ADDR_W-1:0] pc;

  mc_core_gen2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem(mem_if),
    .halted(halted), .illegal_op(illegal_op), .retired(retired), .pc(pc)
  );

  logic [31:0] ram [65536];
  logic [31:0] img [int];
  logic [31:0] mexp [int];
  int ack_delay = 0;
  int no_ack_addr = -1;
  int hold = 0;
  int unstable = 0;
  int ill_cycles = 0;
  logic [ADDR_W-1:0] p_addr = '0;
  logic              p_we = 1'b0;
  logic [31:0]       p_wdata = '0;
  int rd_q[$], wr_addr_q[$], acc_len_q[$];
  logic [31:0] wr_data_q[$];
  int nvec = 0, nmis = 0;
  int ill0, uns0;

  assign mem_if.mem_ack   = mem_if.mem_req && (hold >= ack_delay) && (int'(mem_if.mem_addr) != no_ack_addr);
  assign mem_if.mem_rdata = ram[mem_if.mem_addr];

  always @(posedge clk) begin
    if (reset) begin
      hold <= 0;
    end else if (mem_if.mem_req) begin
      if (hold > 0 && (mem_if.mem_addr != p_addr || mem_if.mem_we != p_we || mem_if.mem_wdata != p_wdata))
        unstable <= unstable + 1;
      p_addr  <= mem_if.mem_addr;
      p_we    <= mem_if.mem_we;
      p_wdata <= mem_if.mem_wdata;
      if (mem_if.mem_ack) begin
        hold <= 0;
        acc_len_q.push_back(hold + 1);
        if (mem_if.mem_we) begin
          ram[mem_if.mem_addr] = mem_if.mem_wdata;
          wr_addr_q.push_back(int'(mem_if.mem_addr));
          wr_data_q.push_back(mem_if.mem_wdata);
        end else begin
          rd_q.push_back(int'(mem_if.mem_addr));
        end
      end else begin
        hold <= hold + 1;
      end
    end else begin
      hold <= 0;
    end
    if (illegal_op) ill_cycles <= ill_cycles + 1;
  end

  function automatic logic [31:0] enc_i(logic [5:0] op, int ra, int rb, logic [15:0] imm);
    return {op, ra[4:0], rb[4:0], imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] op, int rd, int rs, int rt);
    return {op, rd[4:0], rs[4:0], rt[4:0], 11'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Holds reset, loads the image, then releases reset on a falling edge.
  task automatic start(input int d);
    reset = 1'b1;
    ack_delay = d;
    rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); acc_len_q.delete();
    for (int i = 0; i < 65536; i++) ram[i] = 32'd0;
    foreach (img[k]) ram[k] = img[k];
    repeat (2) @(negedge clk);
    ill0 = ill_cycles;
    uns0 = unstable;
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (halted) break;
    end
    if (!halted) begin
      nvec++; nmis++;
      $display("FAIL %s_timeout: halted=0 after %0d cycles, required 1", name, cyc);
    end
  endtask

  // Instruction-level interpreter: cycle cost per instruction from the latency rules.
  task automatic model_run(input int d, output int cyc, output int ret, output int ill);
    logic [31:0] r [32];
    logic [31:0] ins, a, res, imm_s;
    logic [15:0] p, ea;
    logic [4:0]  f1, f2, f3;
    logic [5:0]  op;
    bit stop, has_res;
    mexp = img;
    foreach (r[i]) r[i] = 32'd0;
    p = 16'd0; cyc = 0; ret = 0; ill = 0; stop = 0;
    for (int step = 0; step < 2000 && !stop; step++) begin
      ins = mexp.exists(int'(p)) ? mexp[int'(p)] : 32'd0;
      p = p + 16'd1;
      op = ins[31:26]; f1 = ins[25:21]; f2 = ins[20:16]; f3 = ins[15:11];
      imm_s = {{16{ins[15]}}, ins[15:0]};
      a = r[f2];
      cyc += 1 + d; ret++; has_res = 0; res = 32'd0;
      case (op)
        OP_NOP:  cyc += 1;
        OP_ADD:  begin res = a + r[f3];             has_res = 1; cyc += 3; end
        OP_SUB:  begin res = a - r[f3];             has_res = 1; cyc += 3; end
        OP_AND:  begin res = a & r[f3];             has_res = 1; cyc += 3; end
        OP_OR:   begin res = a | r[f3];             has_res = 1; cyc += 3; end
        OP_ADDI: begin res = a + imm_s;             has_res = 1; cyc += 3; end
        OP_ORI:  begin res = a | {16'd0, ins[15:0]}; has_res = 1; cyc += 3; end
        OP_LW: begin
          ea = 16'(a + imm_s);
          res = mexp.exists(int'(ea)) ? mexp[int'(ea)] : 32'd0;
          has_res = 1; cyc += 4 + d;
        end
        OP_SW: begin
          ea = 16'(a + imm_s);
          mexp[int'(ea)] = r[f1];
          cyc += 3 + d;
        end
        OP_BEQ:  begin if (r[f1] == r[f2]) p = p + ins[15:0]; cyc += 2; end
        OP_J:    begin p = ins[15:0]; cyc += 1; end
        OP_HALT: begin cyc += 1; stop = 1; end
        default: begin ill++; cyc += 1; end
      endcase
      if (has_res && f1 != 5'd0) r[f1] = res;
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    bit          use_imm;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int cyc, ecyc, eret, eill, bad, found;
    tbl[0] = '{OP_ADD,  16'd5,      16'd7,      16'd0,      1'b0, 32'd12};
    tbl[1] = '{OP_SUB,  16'd0,      16'd1,      16'd0,      1'b0, 32'hFFFF_FFFF};
    tbl[2] = '{OP_SUB,  16'd7,      16'd5,      16'd0,      1'b0, 32'd2};
    tbl[3] = '{OP_AND,  16'hF0F0,   16'hFF00,   16'd0,      1'b0, 32'h0000_F000};
    tbl[4] = '{OP_OR,   16'h0F00,   16'h00F0,   16'd0,      1'b0, 32'h0000_0FF0};
    tbl[5] = '{OP_ADD,  16'hFFFF,   16'hFFFF,   16'd0,      1'b0, 32'h0001_FFFE};
    tbl[6] = '{OP_ADDI, 16'd3,      16'd0,      16'hFFFF,   1'b1, 32'd2};
    tbl[7] = '{OP_ORI,  16'h0100,   16'd0,      16'h0011,   1'b1, 32'h0000_0111};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_req", 64'(mem_if.mem_req), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);

    // ORI/ORI/ADD/HALT with combinational ack: halted on cycle 14
    img.delete();
    img[0] = enc_i(OP_ORI, 1, 0, 16'd5);
    img[1] = enc_i(OP_ORI, 2, 0, 16'd7);
    img[2] = enc_r(OP_ADD, 3, 1, 2);
    img[3] = {OP_HALT, 26'd0};
    start(0);
    wait_halt("basic", 40, cyc);
    chk("basic_cycles", 64'(cyc), 64'd14);
    chk("basic_retired", 64'(retired), 64'd4);
    chk("basic_req_halted", 64'(mem_if.mem_req), 64'd0);

    // SW then LW through address 0x20 with every access stretched to 4 cycles
    img.delete();
    img[0] = enc_i(OP_ORI, 1, 0, 16'd5);
    img[1] = enc_i(OP_ORI, 2, 0, 16'd7);
    img[2] = enc_r(OP_ADD, 3, 1, 2);
    img[3] = enc_i(OP_SW, 3, 0, 16'h20);
    img[4] = enc_i(OP_LW, 4, 0, 16'h20);
    img[5] = enc_i(OP_SW, 4, 0, 16'h21);
    img[6] = {OP_HALT, 26'd0};
    start(3);
    wait_halt("swlw", 200, cyc);
    chk("swlw_cycles", 64'(cyc), 64'd57);
    chk("swlw_wr0_addr", 64'(wr_addr_q.size() > 0 ? wr_addr_q[0] : -1), 64'(32'h20));
    chk("swlw_wr0_data", 64'(wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD), 64'd12);
    chk("swlw_lw_value", 64'(ram[16'h21]), 64'd12);
    chk("swlw_accesses", 64'(acc_len_q.size()), 64'd10);
    bad = 0;
    foreach (acc_len_q[i]) if (acc_len_q[i] != 4) bad++;
    chk("swlw_access_len", 64'(bad), 64'd0);
    chk("swlw_stable", 64'(unstable - uns0), 64'd0);
    chk("swlw_retired", 64'(retired), 64'd7);

    // BEQ taken, BEQ not taken, J
    img.delete();
    img[0] = enc_i(OP_ORI, 1, 0, 16'd1);
    img[1] = enc_i(OP_ORI, 2, 0, 16'd2);
    img[2] = 32'd0;
    img[3] = 32'd0;
    img[4] = enc_i(OP_BEQ, 1, 1, 16'd2);
    img[5] = {OP_HALT, 26'd0};
    img[6] = {OP_HALT, 26'd0};
    img[7] = enc_i(OP_BEQ, 1, 2, 16'd5);
    img[8] = {OP_J, 26'h100};
    img[16'h100] = {OP_HALT, 26'd0};
    start(0);
    wait_halt("branch", 60, cyc);
    begin
      int exp_rd [8] = '{0, 1, 2, 3, 4, 7, 8, 32'h100};
      chk("branch_nfetch", 64'(rd_q.size()), 64'd8);
      foreach (exp_rd[i]) chk($sformatf("branch_fetch%0d", i), 64'(rd_q.size() > i ? rd_q[i] : -1), 64'(exp_rd[i]));
    end
    chk("branch_cycles", 64'(cyc), 64'd22);
    chk("branch_retired", 64'(retired), 64'd8);

    // r0 hardwired zero and illegal opcode
    img.delete();
    img[0] = enc_i(OP_ORI, 0, 0, 16'hFFFF);
    img[1] = enc_r(OP_ADD, 5, 0, 0);
    img[2] = enc_i(OP_SW, 5, 0, 16'h30);
    img[3] = {6'h15, 26'h123};
    img[4] = enc_i(OP_SW, 0, 0, 16'h31);
    img[5] = {OP_HALT, 26'd0};
    img[16'h30] = 32'hDEAD;
    img[16'h31] = 32'hBEEF;
    start(0);
    wait_halt("r0ill", 60, cyc);
    chk("r0_add", 64'(ram[16'h30]), 64'd0);
    chk("r0_store", 64'(ram[16'h31]), 64'd0);
    chk("ill_pulse_cycles", 64'(ill_cycles - ill0), 64'd1);
    chk("ill_next_fetch", 64'(rd_q.size() > 4 ? rd_q[4] : -1), 64'd4);
    chk("ill_cycles_total", 64'(cyc), 64'd20);
    chk("ill_retired", 64'(retired), 64'd6);

    // reset during a stalled LW in MEM
    img.delete();
    img[0] = enc_i(OP_ORI, 4, 0, 16'd7);
    img[1] = enc_i(OP_LW, 4, 0, 16'h20);
    img[16'h20] = 32'h1234;
    no_ack_addr = 32'h20;
    start(0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_if.mem_req && mem_if.mem_addr == 16'h20 && !mem_if.mem_we) found = 1;
    end
    chk("rstmem_reached", 64'(found), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    chk("rstmem_req_held", 64'(mem_if.mem_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("rstmem_req_drop", 64'(mem_if.mem_req), 64'd0);
    chk("rstmem_retired", 64'(retired), 64'd0);
    no_ack_addr = -1;
    img.delete();
    img[0] = enc_i(OP_SW, 4, 0, 16'h22);
    img[1] = {OP_HALT, 26'd0};
    img[16'h22] = 32'h5555;
    start(0);
    #1;
    chk("rstmem_first_req", 64'(mem_if.mem_req), 64'd1);
    chk("rstmem_first_addr", 64'(mem_if.mem_addr), 64'd0);
    chk("rstmem_first_we", 64'(mem_if.mem_we), 64'd0);
    wait_halt("rstmem", 40, cyc);
    chk("rstmem_r4_clear", 64'(ram[16'h22]), 64'd0);

    // PC wrap from 0xFFFF to 0
    img.delete();
    img[0] = {OP_J, 26'hFFFE};
    img[16'hFFFE] = 32'd0;
    img[16'hFFFF] = 32'd0;
    start(0);
    for (int i = 0; i < 40 && rd_q.size() < 5; i++) @(posedge clk);
    #1;
    begin
      int exp_w [5] = '{0, 32'hFFFE, 32'hFFFF, 0, 32'hFFFE};
      foreach (exp_w[i]) chk($sformatf("wrap_fetch%0d", i), 64'(rd_q.size() > i ? rd_q[i] : -1), 64'(exp_w[i]));
    end

    // table-driven single-operation vectors
    for (int v = 0; v < 8; v++) begin
      img.delete();
      img[0] = enc_i(OP_ORI, 2, 0, tbl[v].a);
      img[1] = enc_i(OP_ORI, 3, 0, tbl[v].b);
      img[2] = tbl[v].use_imm ? enc_i(tbl[v].op, 1, 2, tbl[v].imm) : enc_r(tbl[v].op, 1, 2, 3);
      img[3] = enc_i(OP_SW, 1, 0, 16'h40);
      img[4] = {OP_HALT, 26'd0};
      start(0);
      wait_halt($sformatf("tbl%0d", v), 40, cyc);
      chk($sformatf("tbl%0d_result", v), 64'(ram[16'h40]), 64'(tbl[v].exp));
      chk($sformatf("tbl%0d_cycles", v), 64'(cyc), 64'd18);
    end

    // random straight-line programs against the interpreter
    for (int t = 0; t < 20; t++) begin
      int d;
      d = $urandom_range(0, 2);
      img.delete();
      for (int k = 0; k < 8; k++) img[32'h200 + k] = $urandom;
      for (int k = 0; k < 16; k++) begin
        int kind, rd, rs, rt;
        logic [15:0] imm;
        kind = $urandom_range(0, 9);
        rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
        imm = 16'($urandom);
        case (kind)
          0: img[k] = enc_r(OP_ADD, rd, rs, rt);
          1: img[k] = enc_r(OP_SUB, rd, rs, rt);
          2: img[k] = enc_r(OP_AND, rd, rs, rt);
          3: img[k] = enc_r(OP_OR, rd, rs, rt);
          4: img[k] = enc_i(OP_ADDI, rd, rs, imm);
          5: img[k] = enc_i(OP_ORI, rd, rs, imm);
          6: img[k] = enc_i(OP_LW, rd, 0, 16'h200 + 16'(rt));
          7: img[k] = enc_i(OP_SW, rd, 0, 16'h200 + 16'(rt));
          8: img[k] = 32'd0;
          default: img[k] = {6'h2A, 26'(imm)};
        endcase
      end
      for (int k = 1; k < 8; k++) img[15 + k] = enc_i(OP_SW, k, 0, 16'h210 + 16'(k));
      img[23] = {OP_HALT, 26'd0};
      model_run(d, ecyc, eret, eill);
      start(d);
      wait_halt($sformatf("rnd%0d", t), ecyc + 20, cyc);
      chk($sformatf("rnd%0d_cycles", t), 64'(cyc), 64'(ecyc));
      chk($sformatf("rnd%0d_retired", t), 64'(retired), 64'(eret));
      chk($sformatf("rnd%0d_illegal", t), 64'(ill_cycles - ill0), 64'(eill));
      for (int a = 32'h200; a < 32'h218; a++) begin
        if (a < 32'h208 || a > 32'h210)
          chk($sformatf("rnd%0d_mem%0h", t, a), 64'(ram[a]), 64'(mexp.exists(a) ? mexp[a] : 32'd0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
